// File: rtl/adler_pkg.sv
// Shared constants and state encoding for the wide Adler-32 engine.
package adler_pkg;

    localparam logic [15:0] ADLER_MOD  = 16'd65521;
    localparam logic [31:0] ADLER_INIT = 32'h0000_0001;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

endpackage

// File: rtl/adler_mod65521.sv
// Combinational reduction of a 24-bit partial sum to its residue mod 65521.
module adler_mod65521
    import adler_pkg::*;
(
    input  logic [23:0] x,
    output logic [15:0] y
);

    logic [16:0] fold1;
    logic [16:0] fold2;

    // 2^16 mod 65521 = 15, so the upper byte folds back in with weight 15
    always_comb begin
        fold1 = 17'(x[23:16]) * 17'd15 + 17'(x[15:0]);
        fold2 = 17'(fold1[15:0]) + (fold1[16] ? 17'd15 : 17'd0);
        if (fold2 >= 17'(ADLER_MOD)) begin
            y = 16'(fold2 - 17'(ADLER_MOD));
        end else begin
            y = fold2[15:0];
        end
    end

endmodule

// File: rtl/adler32_wide.sv
// Adler-32 checksum engine accepting NBYTES bytes per beat, with seedable A/B.
module adler32_wide
    import adler_pkg::*;
#(
    parameter int NBYTES = 4,
    parameter int CW     = $clog2(NBYTES) + 1
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  data_valid,
    input  logic [8*NBYTES-1:0]   data,
    input  logic                  last_data,
    input  logic [CW-1:0]         last_count,
    input  logic                  seed_valid,
    input  logic [31:0]           seed,
    output logic                  busy,
    output logic                  checksum_valid,
    output logic [31:0]           checksum
);

    state_t        state;
    state_t        state_next;
    logic [15:0]   a_acc;
    logic [15:0]   b_acc;
    logic          seed_pending;
    logic [31:0]   seed_hold;
    logic [15:0]   a_start;
    logic [15:0]   b_start;
    logic [CW-1:0] nvalid;
    logic [23:0]   byte_sum;
    logic [23:0]   weighted;
    logic [23:0]   a_raw;
    logic [23:0]   b_raw;
    logic [15:0]   a_next;
    logic [15:0]   b_next;

    // A message resumes from the accumulators; a first beat picks seed, pending seed or init
    always_comb begin
        if (state == ACCUM) begin
            a_start = a_acc;
            b_start = b_acc;
        end else if (seed_valid) begin
            {b_start, a_start} = seed;
        end else if (seed_pending) begin
            {b_start, a_start} = seed_hold;
        end else begin
            {b_start, a_start} = ADLER_INIT;
        end
    end

    assign nvalid = last_data ? last_count : CW'(NBYTES);

    // Lane i contributes once to A and (k - i) times to B within the beat
    always_comb begin
        byte_sum = '0;
        weighted = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (i < int'(nvalid)) begin
                byte_sum = byte_sum + 24'(data[8*i +: 8]);
                weighted = weighted + 24'(data[8*i +: 8]) * 24'(int'(nvalid) - i);
            end
        end
        a_raw = 24'(a_start) + byte_sum;
        b_raw = 24'(b_start) + 24'(nvalid) * 24'(a_start) + weighted;
    end

    adler_mod65521 u_mod_a (.x(a_raw), .y(a_next));
    adler_mod65521 u_mod_b (.x(b_raw), .y(b_next));

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (data_valid) begin
            state_next = last_data ? IDLE : ACCUM;
        end
    end

    always_comb begin
        busy = (state == ACCUM);
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            a_acc          <= 16'd1;
            b_acc          <= 16'd0;
            seed_pending   <= 1'b0;
            checksum_valid <= 1'b0;
            checksum       <= 32'h0;
        end else begin
            if (data_valid) begin
                a_acc <= a_next;
                b_acc <= b_next;
            end
            checksum_valid <= data_valid & last_data;
            if (data_valid && last_data) begin
                checksum <= {b_next, a_next};
            end
            if (state == IDLE) begin
                if (data_valid) begin
                    seed_pending <= 1'b0;
                end else if (seed_valid) begin
                    seed_pending <= 1'b1;
                end
            end
        end
    end

    // Seed value only matters while seed_pending is set, so it needs no reset
    always_ff @(posedge clock) begin
        if (state == IDLE && !data_valid && seed_valid) begin
            seed_hold <= seed;
        end
    end

endmodule
